// File: rtl/alu_uart_ctrl.sv
// -----------------------------------------------------------------------------
// alu_uart_ctrl
//
// Sequences one ALU operation per three received UART bytes:
//   byte 1 -> operand A, byte 2 -> operand B, byte 3 -> opcode (SIZEOP LSBs),
// then latches the ALU result and fires a one-cycle start pulse at the UART
// transmitter, waiting for its done pulse before accepting the next operand A.
//
// Handshake: i_rx_done / i_tx_done are single-cycle "valid" strobes with no
// back-pressure. A received byte the controller cannot take (while computing,
// sending, or waiting on the transmitter) is dropped and flagged with a
// one-cycle o_overrun pulse; state is not disturbed by a dropped byte.
//
// Optional feature macro: ALU_UART_PARITY_CHECK_EN
//   defined     - even-parity check on received bytes (a mismatch restarts at
//                 operand A and pulses o_overrun); o_tx_parity = ^result.
//   not defined - i_rx_parity ignored; o_tx_parity is constant 1.
//
// Ports:
//   i_clock, i_reset      clock, asynchronous active-high reset
//   i_rx_done/data/parity received byte strobe, byte, parity bit
//   i_alu_result          combinational ALU result for o_op_a/o_op_b/o_opcode
//   i_tx_done             transmitter frame-finished strobe
//   o_op_a, o_op_b        registered operands to ALU
//   o_opcode              registered opcode to ALU
//   o_tx_signal           one-cycle transmit start pulse
//   o_tx_result           registered result byte to transmitter
//   o_tx_parity           parity bit to transmitter
//   o_busy                high while computing / sending / waiting for tx
//   o_overrun             one-cycle pulse when a received byte is dropped
//   o_state               debug view of the FSM state register
// -----------------------------------------------------------------------------
module alu_uart_ctrl #(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [SIZEDATA-1:0] i_rx_data,
    input  logic                i_rx_parity,
    input  logic [SIZEDATA-1:0] i_alu_result,
    input  logic                i_tx_done,
    output logic [SIZEDATA-1:0] o_op_a,
    output logic [SIZEDATA-1:0] o_op_b,
    output logic [SIZEOP-1:0]   o_opcode,
    output logic                o_tx_signal,
    output logic [SIZEDATA-1:0] o_tx_result,
    output logic                o_tx_parity,
    output logic                o_busy,
    output logic                o_overrun,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t state, next_state;
    logic   cap_a, cap_b, cap_op, cap_res, drop;
    logic   par_ok;

`ifdef ALU_UART_PARITY_CHECK_EN
    assign par_ok = ((^i_rx_data) == i_rx_parity);
`else
    logic unused_rx_parity;
    assign unused_rx_parity = i_rx_parity;
    assign par_ok           = 1'b1;
`endif

    assign o_state = state;

    // Next state, capture enables and drop detection.
    always_comb begin
        next_state = state;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        cap_op     = 1'b0;
        cap_res    = 1'b0;
        drop       = 1'b0;
        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    if (par_ok) begin
                        cap_a      = 1'b1;
                        next_state = WAIT_B;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    if (par_ok) begin
                        cap_b      = 1'b1;
                        next_state = WAIT_OP;
                    end else begin
                        drop       = 1'b1;
                        next_state = WAIT_A;
                    end
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    if (par_ok) begin
                        cap_op     = 1'b1;
                        next_state = EXEC;
                    end else begin
                        drop       = 1'b1;
                        next_state = WAIT_A;
                    end
                end
            end
            EXEC: begin
                cap_res    = 1'b1;
                drop       = i_rx_done;
                next_state = SEND;
            end
            SEND: begin
                drop       = i_rx_done;
                next_state = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    // A byte landing together with tx completion is the next
                    // operand A, not an overrun.
                    next_state = WAIT_A;
                    if (i_rx_done) begin
                        if (par_ok) begin
                            cap_a      = 1'b1;
                            next_state = WAIT_B;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end else begin
                    drop = i_rx_done;
                end
            end
            default: next_state = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs; o_busy and o_tx_signal are decoded from the next
    // state so they line up exactly with the state they describe.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_op_a      <= '0;
            o_op_b      <= '0;
            o_opcode    <= '0;
            o_tx_result <= '0;
            o_tx_signal <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (cap_a)   o_op_a      <= i_rx_data;
            if (cap_b)   o_op_b      <= i_rx_data;
            if (cap_op)  o_opcode    <= i_rx_data[SIZEOP-1:0];
            if (cap_res) o_tx_result <= i_alu_result;
            o_tx_signal <= (next_state == SEND);
            o_busy      <= (next_state == EXEC) || (next_state == SEND) ||
                           (next_state == WAIT_TX);
            o_overrun   <= drop;
        end
    end

`ifdef ALU_UART_PARITY_CHECK_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_tx_parity <= 1'b1;
        end else if (cap_res) begin
            o_tx_parity <= ^i_alu_result;
        end
    end
`else
    assign o_tx_parity = 1'b1;
`endif

endmodule

// File: tb/tb_alu_uart_ctrl.sv
module tb_alu_uart_ctrl;

    localparam int W  = 8;
    localparam int OW = 6;

    localparam logic [2:0] S_WAIT_A  = 3'd0;
    localparam logic [2:0] S_WAIT_B  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_WAIT_TX = 3'd5;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_rx_done = 1'b0;
    logic [W-1:0]  i_rx_data = '0;
    logic          i_rx_parity = 1'b0;
    logic [W-1:0]  i_alu_result;
    logic          i_tx_done = 1'b0;
    logic [W-1:0]  o_op_a, o_op_b, o_tx_result;
    logic [OW-1:0] o_opcode;
    logic          o_tx_signal, o_tx_parity, o_busy, o_overrun;
    logic [2:0]    o_state;

    int n_vec   = 0;
    int n_err   = 0;
    int n_pulse = 0;
    int n_push  = 0;
    logic [W-1:0] exp_q[$];

    alu_uart_ctrl #(.SIZEDATA(W), .SIZEOP(OW)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_rx_done(i_rx_done), .i_rx_data(i_rx_data), .i_rx_parity(i_rx_parity),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
        .o_op_a(o_op_a), .o_op_b(o_op_b), .o_opcode(o_opcode),
        .o_tx_signal(o_tx_signal), .o_tx_result(o_tx_result),
        .o_tx_parity(o_tx_parity), .o_busy(o_busy), .o_overrun(o_overrun),
        .o_state(o_state)
    );

    // ---------------- clock ----------------
    always #5 i_clock = ~i_clock;

    // ---------------- ALU model (stimulus side) ----------------
    logic signed [W-1:0] sa;
    always_comb begin
        sa = o_op_a;
        case (o_opcode)
            6'h20:   i_alu_result = o_op_a + o_op_b;
            6'h22:   i_alu_result = o_op_a - o_op_b;
            6'h24:   i_alu_result = o_op_a & o_op_b;
            6'h25:   i_alu_result = o_op_a | o_op_b;
            6'h26:   i_alu_result = o_op_a ^ o_op_b;
            6'h27:   i_alu_result = ~(o_op_a | o_op_b);
            6'h03:   i_alu_result = sa >>> o_op_b[2:0];
            6'h02:   i_alu_result = o_op_a >> o_op_b[2:0];
            default: i_alu_result = '0;
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every transmit start pulse must carry the next expected result.
    always @(negedge i_clock) begin
        if (o_tx_signal) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                check("unexpected_tx_pulse", 32'(o_tx_result), 32'hFFFF_FFFF);
            end else begin
                check("sb_tx_result", 32'(o_tx_result), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic rx_byte(input logic [W-1:0] d, input bit good);
        @(negedge i_clock);
        i_rx_data   = d;
        i_rx_parity = good ? ^d : ~(^d);
        i_rx_done   = 1'b1;
        @(negedge i_clock);
        i_rx_done   = 1'b0;
    endtask

    task automatic finish_tx();
        @(negedge i_clock);
        i_tx_done = 1'b1;
        @(negedge i_clock);
        i_tx_done = 1'b0;
        check("state_after_tx_done", 32'(o_state), 32'(S_WAIT_A));
        check("busy_after_tx_done", 32'(o_busy), 32'd0);
    endtask

    // Operand A already captured: send B and opcode, follow to WAIT_TX.
    task automatic complete_txn(input logic [W-1:0] b, input logic [W-1:0] op,
                                input logic [W-1:0] exp);
        rx_byte(b, 1'b1);
        check("op_b", 32'(o_op_b), 32'(b));
        exp_q.push_back(exp);
        n_push++;
        rx_byte(op, 1'b1);
        check("opcode", 32'(o_opcode), 32'(op[OW-1:0]));
        check("state_exec", 32'(o_state), 32'(S_EXEC));
        check("busy_exec", 32'(o_busy), 32'd1);
        check("tx_signal_exec", 32'(o_tx_signal), 32'd0);
        @(negedge i_clock);
        check("tx_signal_send", 32'(o_tx_signal), 32'd1);
        check("tx_result_send", 32'(o_tx_result), 32'(exp));
        @(negedge i_clock);
        check("tx_signal_wait", 32'(o_tx_signal), 32'd0);
        check("state_wait_tx", 32'(o_state), 32'(S_WAIT_TX));
        check("tx_result_wait", 32'(o_tx_result), 32'(exp));
`ifdef ALU_UART_PARITY_CHECK_EN
        check("tx_parity", 32'(o_tx_parity), 32'(^exp));
`else
        check("tx_parity", 32'(o_tx_parity), 32'd1);
`endif
    endtask

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] op, input logic [W-1:0] exp);
        rx_byte(a, 1'b1);
        check("op_a", 32'(o_op_a), 32'(a));
        check("state_wait_b", 32'(o_state), 32'(S_WAIT_B));
        complete_txn(b, op, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_op_a"}, 32'(o_op_a), 32'd0);
        check({tag, "_op_b"}, 32'(o_op_b), 32'd0);
        check({tag, "_opcode"}, 32'(o_opcode), 32'd0);
        check({tag, "_tx_result"}, 32'(o_tx_result), 32'd0);
        check({tag, "_tx_signal"}, 32'(o_tx_signal), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_overrun"}, 32'(o_overrun), 32'd0);
        check({tag, "_tx_parity"}, 32'(o_tx_parity), 32'd1);
        check({tag, "_state"}, 32'(o_state), 32'(S_WAIT_A));
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] op;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};  // add
        vecs[1] = '{8'h10, 8'h03, 8'h22, 8'h0D};  // sub
        vecs[2] = '{8'hA0, 8'h0C, 8'h25, 8'hAC};  // or
        vecs[3] = '{8'hFF, 8'h0F, 8'h26, 8'hF0};  // xor
        vecs[4] = '{8'hF0, 8'h3C, 8'h24, 8'h30};  // and
        vecs[5] = '{8'h0F, 8'hF0, 8'h27, 8'h00};  // nor
        vecs[6] = '{8'h80, 8'h02, 8'h03, 8'hE0};  // arithmetic shift right
        vecs[7] = '{8'h80, 8'h03, 8'h02, 8'h10};  // logical shift right

        repeat (3) @(negedge i_clock);
        check_reset_values("reset");
        i_reset = 1'b0;

        // tx_done outside WAIT_TX is ignored
        @(negedge i_clock);
        i_tx_done = 1'b1;
        @(negedge i_clock);
        i_tx_done = 1'b0;
        check("tx_done_idle_state", 32'(o_state), 32'(S_WAIT_A));

        // back-to-back transactions from the table
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
            finish_tx();
        end

        // extra byte while waiting for the transmitter is dropped
        run_txn(8'h05, 8'h03, 8'h20, 8'h08);
        rx_byte(8'h7F, 1'b1);
        check("overrun_wait_tx", 32'(o_overrun), 32'd1);
        check("op_a_kept", 32'(o_op_a), 32'h05);
        check("state_kept", 32'(o_state), 32'(S_WAIT_TX));
        check("tx_result_kept", 32'(o_tx_result), 32'h08);
        @(negedge i_clock);
        check("overrun_one_cycle", 32'(o_overrun), 32'd0);
        finish_tx();

        // rx_done and tx_done in the same cycle: byte becomes operand A
        run_txn(8'h01, 8'h01, 8'h20, 8'h02);
        @(negedge i_clock);
        i_rx_data   = 8'h11;
        i_rx_parity = ^8'h11;
        i_rx_done   = 1'b1;
        i_tx_done   = 1'b1;
        @(negedge i_clock);
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        check("simul_state", 32'(o_state), 32'(S_WAIT_B));
        check("simul_op_a", 32'(o_op_a), 32'h11);
        check("simul_overrun", 32'(o_overrun), 32'd0);
        complete_txn(8'h22, 8'h20, 8'h33);
        finish_tx();

        // byte during EXEC dropped; opcode upper bits ignored
        rx_byte(8'h09, 1'b1);
        rx_byte(8'h06, 1'b1);
        exp_q.push_back(8'h0F);
        n_push++;
        @(negedge i_clock);
        i_rx_data   = 8'hE0;
        i_rx_parity = ^8'hE0;
        i_rx_done   = 1'b1;
        @(negedge i_clock);
        check("opcode_masked", 32'(o_opcode), 32'h20);
        check("state_exec2", 32'(o_state), 32'(S_EXEC));
        i_rx_data   = 8'h55;
        i_rx_parity = ^8'h55;
        @(negedge i_clock);
        i_rx_done = 1'b0;
        check("overrun_exec", 32'(o_overrun), 32'd1);
        check("state_send", 32'(o_state), 32'(S_SEND));
        check("op_a_exec_kept", 32'(o_op_a), 32'h09);
        check("tx_result_exec", 32'(o_tx_result), 32'h0F);
        @(negedge i_clock);
        check("overrun_exec_clear", 32'(o_overrun), 32'd0);
        finish_tx();

        // asynchronous reset mid-transaction
        rx_byte(8'h12, 1'b1);
        rx_byte(8'h34, 1'b1);
        #2;
        i_reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(negedge i_clock);
        i_reset = 1'b0;
        run_txn(8'h21, 8'h13, 8'h22, 8'h0E);
        finish_tx();

`ifdef ALU_UART_PARITY_CHECK_EN
        // bad parity on operand B restarts at operand A
        rx_byte(8'h05, 1'b1);
        rx_byte(8'h03, 1'b0);
        check("parity_overrun", 32'(o_overrun), 32'd1);
        check("parity_state", 32'(o_state), 32'(S_WAIT_A));
        @(negedge i_clock);
        check("parity_overrun_clear", 32'(o_overrun), 32'd0);
        run_txn(8'h04, 8'h03, 8'h20, 8'h07);
        finish_tx();
`endif

        repeat (2) @(negedge i_clock);
        check("pulse_count", 32'(n_pulse), 32'(n_push));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
